// File: rtl/board_mem_arbiter.sv
// board_mem_arbiter: shares the single-port playfield RAM between the
// fixed-latency pixel renderer and the handshaked game logic. It also
// derives a vblank window and a once-per-frame tick from the sync timing.
// Optional build macro WRITE_FENCE_EN: game writes are granted only in vblank.
module board_mem_arbiter #(
  parameter int unsigned ADDR_W        = 8,
  parameter int unsigned DATA_W        = 3,
  parameter int unsigned CELL_COUNT    = 200,
  parameter int unsigned HBLANK_CYCLES = 160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              video_on,
  input  logic              vsync,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [DATA_W-1:0] gl_wdata,
  output logic              gl_ack,
  output logic [DATA_W-1:0] gl_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              frame_tick,
  output logic              vblank
);

  // Blank counter saturates one past the hblank length, which is all vblank needs
  localparam int unsigned      CNT_W   = $clog2(HBLANK_CYCLES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HBLANK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_THR = CNT_W'(HBLANK_CYCLES);

  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_ISSUE = 2'd1,
    G_RWAIT = 2'd2,
    G_ACK   = 2'd3
  } gstate_e;

  gstate_e           state_q, state_d;
  logic              rd_s1_q, rd_s1_d;
  logic              rd_s1_ok_q, rd_s1_ok_d;
  logic              rd_s2_q, rd_s2_d;
  logic              rd_s2_ok_q, rd_s2_ok_d;
  logic              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              gl_ack_q, gl_ack_d;
  logic [DATA_W-1:0] gl_rdata_q, gl_rdata_d;
  logic              gl_we_q, gl_we_d;
  logic              gl_ok_q, gl_ok_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              vs_prev_q, vs_prev_d;
  logic              frame_tick_q, frame_tick_d;
  logic [CNT_W-1:0]  blank_cnt_q, blank_cnt_d;
  logic              vblank_q, vblank_d;

  logic rd_in_range_c;
  logic gl_in_range_c;
  logic gl_window_c;

  assign rd_in_range_c = (32'(rd_addr) < CELL_COUNT);
  assign gl_in_range_c = (32'(gl_addr) < CELL_COUNT);

`ifdef WRITE_FENCE_EN
  // Writes wait for true vertical blank to avoid tearing; reads use any blank
  assign gl_window_c = gl_we ? vblank_q : ~video_on;
`else
  assign gl_window_c = ~video_on;
`endif

  // Next-state: renderer pipeline, game FSM, RAM port mux, blank/frame timing
  always_comb begin
    state_d      = state_q;
    gl_ack_d     = 1'b0;
    gl_rdata_d   = gl_rdata_q;
    gl_we_d      = gl_we_q;
    gl_ok_d      = gl_ok_q;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;

    rd_s1_d      = rd_req;
    rd_s1_ok_d   = rd_req & rd_in_range_c;
    rd_s2_d      = rd_s1_q;
    rd_s2_ok_d   = rd_s1_ok_q;
    rd_valid_d   = rd_s2_q;
    rd_data_d    = rd_s2_ok_q ? mem_rdata : '0;

    if (rd_req && rd_in_range_c) begin
      mem_en_d   = 1'b1;
      mem_addr_d = rd_addr;
    end

    unique case (state_q)
      G_IDLE: begin
        // Renderer always wins the port, so the game only issues in idle cycles
        if (gl_req && gl_window_c && !rd_req) begin
          state_d = G_ISSUE;
          gl_we_d = gl_we;
          gl_ok_d = gl_in_range_c;
          if (gl_in_range_c) begin
            mem_en_d    = 1'b1;
            mem_we_d    = gl_we;
            mem_addr_d  = gl_addr;
            mem_wdata_d = gl_we ? gl_wdata : '0;
          end
        end
      end
      G_ISSUE: begin
        if (gl_we_q) begin
          state_d  = G_ACK;
          gl_ack_d = 1'b1;
        end else begin
          state_d = G_RWAIT;
        end
      end
      G_RWAIT: begin
        state_d    = G_ACK;
        gl_ack_d   = 1'b1;
        gl_rdata_d = gl_ok_q ? mem_rdata : '0;
      end
      G_ACK: begin
        state_d = G_IDLE;
      end
      default: begin
        state_d = G_IDLE;
      end
    endcase

    if (video_on) begin
      blank_cnt_d = '0;
    end else if (blank_cnt_q != CNT_MAX) begin
      blank_cnt_d = blank_cnt_q + CNT_W'(1);
    end else begin
      blank_cnt_d = blank_cnt_q;
    end
    vblank_d     = (blank_cnt_d > CNT_THR);

    vs_prev_d    = vsync;
    frame_tick_d = vs_prev_q & ~vsync;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= G_IDLE;
      rd_s1_q      <= 1'b0;
      rd_s1_ok_q   <= 1'b0;
      rd_s2_q      <= 1'b0;
      rd_s2_ok_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      gl_ack_q     <= 1'b0;
      gl_rdata_q   <= '0;
      gl_we_q      <= 1'b0;
      gl_ok_q      <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      vs_prev_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      blank_cnt_q  <= '0;
      vblank_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_s1_q      <= rd_s1_d;
      rd_s1_ok_q   <= rd_s1_ok_d;
      rd_s2_q      <= rd_s2_d;
      rd_s2_ok_q   <= rd_s2_ok_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
      gl_ack_q     <= gl_ack_d;
      gl_rdata_q   <= gl_rdata_d;
      gl_we_q      <= gl_we_d;
      gl_ok_q      <= gl_ok_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      vs_prev_q    <= vs_prev_d;
      frame_tick_q <= frame_tick_d;
      blank_cnt_q  <= blank_cnt_d;
      vblank_q     <= vblank_d;
    end
  end

  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign gl_ack     = gl_ack_q;
  assign gl_rdata   = gl_rdata_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign frame_tick = frame_tick_q;
  assign vblank     = vblank_q;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Bench for board_mem_arbiter: a bench-side RAM plus a cycle-scheduled
// reference model of the arbitration rules (latencies, priority, blank window).
`timescale 1ns/1ps
module tb_board_mem_arbiter;

  localparam int unsigned ADDR_W        = 8;
  localparam int unsigned DATA_W        = 3;
  localparam int unsigned CELL_COUNT    = 200;
  localparam int unsigned HBLANK_CYCLES = 160;
  localparam int unsigned MEM_DEPTH     = 1 << ADDR_W;
  localparam int          NCYC          = 8192;

  logic              clk = 1'b0;
  logic              rst;
  logic              video_on;
  logic              vsync;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              gl_req;
  logic              gl_we;
  logic [ADDR_W-1:0] gl_addr;
  logic [DATA_W-1:0] gl_wdata;
  logic              gl_ack;
  logic [DATA_W-1:0] gl_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              frame_tick;
  logic              vblank;

  always #5 clk = ~clk;

  board_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CELL_COUNT(CELL_COUNT), .HBLANK_CYCLES(HBLANK_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .video_on(video_on), .vsync(vsync),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
    .gl_ack(gl_ack), .gl_rdata(gl_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .frame_tick(frame_tick), .vblank(vblank)
  );

  // Bench RAM: one-cycle read latency after the registered enable
  logic [DATA_W-1:0] ram      [MEM_DEPTH];
  logic [DATA_W-1:0] init_mem [MEM_DEPTH];
  logic              ram_load;
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) ram[i] <= init_mem[i];
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model: expected outputs scheduled by absolute cycle number
  bit                exp_rv   [NCYC];
  logic [DATA_W-1:0] exp_rd   [NCYC];
  bit                exp_ack  [NCYC];
  logic [DATA_W-1:0] exp_grd  [NCYC];
  bit                exp_en   [NCYC];
  bit                exp_we   [NCYC];
  logic [ADDR_W-1:0] exp_addr [NCYC];
  logic [DATA_W-1:0] exp_wd   [NCYC];
  bit                exp_tick [NCYC];
  bit                exp_zero [NCYC];
  logic [DATA_W-1:0] ref_mem  [MEM_DEPTH];

  int  cyc;
  int  zcount;
  int  g_free;
  bit  vs_prev;
  bit  ack_seen;
  bit  g_granted;
  bit  g_auto;
  logic              g_req;
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

  int n_checks;
  int n_fail;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit vb_exp;
    vb_exp = (zcount > int'(HBLANK_CYCLES));
    check_val("rd_valid", 32'(rd_valid), 32'(exp_rv[cyc]));
    if (exp_rv[cyc]) check_val("rd_data", 32'(rd_data), 32'(exp_rd[cyc]));
    check_val("gl_ack", 32'(gl_ack), 32'(exp_ack[cyc]));
    if (exp_ack[cyc]) check_val("gl_rdata", 32'(gl_rdata), 32'(exp_grd[cyc]));
    check_val("mem_en", 32'(mem_en), 32'(exp_en[cyc]));
    if (exp_en[cyc]) begin
      check_val("mem_we", 32'(mem_we), 32'(exp_we[cyc]));
      check_val("mem_addr", 32'(mem_addr), 32'(exp_addr[cyc]));
      if (exp_we[cyc]) check_val("mem_wdata", 32'(mem_wdata), 32'(exp_wd[cyc]));
    end
    check_val("frame_tick", 32'(frame_tick), 32'(exp_tick[cyc]));
    check_val("vblank", 32'(vblank), 32'(vb_exp));
    if (exp_zero[cyc]) begin
      check_val("rst_rd_data", 32'(rd_data), 32'(0));
      check_val("rst_gl_rdata", 32'(gl_rdata), 32'(0));
      check_val("rst_mem_we", 32'(mem_we), 32'(0));
      check_val("rst_mem_addr", 32'(mem_addr), 32'(0));
      check_val("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    end
  endtask

  // One clock: check this cycle's outputs, drive inputs, advance the model
  task automatic run_cycle(input logic r, input logic von, input logic vs,
                           input logic rq, input logic [ADDR_W-1:0] ra);
    bit vb_now;
    bit win;
    bit in_r;
    bit in_g;
    check_outputs();
    ack_seen = (gl_ack === 1'b1);
    if (ack_seen) begin
      g_req = 1'b0;
    end else if (g_auto && !g_req && $urandom_range(0, 99) < 30) begin
      g_req   = 1'b1;
      g_we    = 1'($urandom_range(0, 1));
      g_addr  = ($urandom_range(0, 4) == 0) ? ADDR_W'($urandom_range(200, 255))
                                            : ADDR_W'($urandom_range(0, 199));
      g_wdata = DATA_W'($urandom());
    end
    rst = r; video_on = von; vsync = vs; rd_req = rq; rd_addr = ra;
    gl_req = g_req; gl_we = g_we; gl_addr = g_addr; gl_wdata = g_wdata;

    vb_now    = (zcount > int'(HBLANK_CYCLES));
    g_granted = 1'b0;
    if (r) begin
      for (int k = 1; k <= 3; k++) begin
        exp_rv[cyc+k] = 1'b0; exp_ack[cyc+k] = 1'b0;
        exp_en[cyc+k] = 1'b0; exp_tick[cyc+k] = 1'b0;
      end
      exp_zero[cyc+1] = 1'b1;
      zcount  = 0;
      vs_prev = 1'b0;
      g_free  = cyc + 1;
    end else begin
      in_r = (int'(ra) < int'(CELL_COUNT));
      if (rq) begin
        exp_rv[cyc+3] = 1'b1;
        exp_rd[cyc+3] = in_r ? ref_mem[ra] : '0;
        if (in_r) begin
          exp_en[cyc+1] = 1'b1; exp_we[cyc+1] = 1'b0; exp_addr[cyc+1] = ra;
        end
      end
      win = !von;
`ifdef WRITE_FENCE_EN
      if (g_we) win = vb_now;
`endif
      if (cyc >= g_free && g_req === 1'b1 && win && !rq) begin
        g_granted = 1'b1;
        in_g = (int'(g_addr) < int'(CELL_COUNT));
        if (in_g) begin
          exp_en[cyc+1] = 1'b1; exp_we[cyc+1] = g_we;
          exp_addr[cyc+1] = g_addr; exp_wd[cyc+1] = g_wdata;
        end
        if (g_we) begin
          if (in_g) ref_mem[g_addr] = g_wdata;
          exp_ack[cyc+2] = 1'b1;
          exp_grd[cyc+2] = gl_rdata;
          g_free = cyc + 3;
        end else begin
          exp_ack[cyc+3] = 1'b1;
          exp_grd[cyc+3] = in_g ? ref_mem[g_addr] : '0;
          g_free = cyc + 4;
        end
      end
      if (vs_prev && !vs) exp_tick[cyc+1] = 1'b1;
      vs_prev = vs;
      zcount  = von ? 0 : zcount + 1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ack(input logic von, input int budget);
    int k;
    k = 0;
    ack_seen = 1'b0;
    while (!ack_seen && k < budget) begin
      run_cycle(1'b0, von, 1'b1, 1'b0, '0);
      k++;
    end
    check_val("ack_wait", 32'(ack_seen), 32'(1));
  endtask

  initial begin
    logic              von_r;
    logic              vs_r;
    int                run_len;
    int                k;

    n_checks = 0; n_fail = 0; cyc = 0; zcount = 0; g_free = 0; vs_prev = 1'b0;
    g_auto = 1'b0; g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
    ack_seen = 1'b0; g_granted = 1'b0;
    rst = 1'b1; video_on = 1'b1; vsync = 1'b1; rd_req = 1'b0; rd_addr = '0;
    gl_req = 1'b0; gl_we = 1'b0; gl_addr = '0; gl_wdata = '0;
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      init_mem[i] = DATA_W'($urandom());
      ref_mem[i]  = init_mem[i];
    end
    init_mem[5] = 3'd6; ref_mem[5] = 3'd6;
    ram_load = 1'b1;
    @(posedge clk);
    #1;
    ram_load = 1'b0;
    exp_zero[0] = 1'b1;
    repeat (2) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);

    // Renderer latency on a known cell
    run_cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'd5);
    repeat (4) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    check_val("ref_cell5", 32'(ref_mem[5]), 32'(6));

    // Game write then read of cell 17
    g_req = 1'b1; g_we = 1'b1; g_addr = 8'd17; g_wdata = 3'd4;
    wait_ack(1'b0, 200);
    g_req = 1'b1; g_we = 1'b0; g_addr = 8'd17;
    wait_ack(1'b0, 10);

    // Contention: renderer holds the port for four cycles
    g_req = 1'b1; g_we = 1'b0; g_addr = 8'd30;
    for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0, 1'b1, 1'b1, ADDR_W'(i * 3 + 1));
    wait_ack(1'b0, 10);

    // Blocked window: active display for 100 cycles with a pending read
    g_req = 1'b1; g_we = 1'b0; g_addr = 8'd40;
    for (int i = 0; i < 100; i++) run_cycle(1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 255)));
    wait_ack(1'b0, 10);

    // Range edges
    g_req = 1'b1; g_we = 1'b1; g_addr = 8'd200; g_wdata = 3'd7;
    wait_ack(1'b0, 200);
    g_req = 1'b1; g_we = 1'b0; g_addr = 8'd255;
    wait_ack(1'b0, 10);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'd250);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'd199);
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'd200);
    repeat (4) run_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Frame tick on vsync falling edge
    repeat (2) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    repeat (3) run_cycle(1'b0, 1'b1, 1'b0, 1'b0, '0);
    repeat (2) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Reset while a game read waits for RAM data
    g_req = 1'b1; g_we = 1'b0; g_addr = 8'd9;
    k = 0;
    g_granted = 1'b0;
    while (!g_granted && k < 10) begin
      run_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
      k++;
    end
    check_val("rwait_grant", 32'(g_granted), 32'(1));
    run_cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'd12);
    g_req = 1'b0;
    run_cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'd13);
    repeat (5) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Write held across one horizontal blank, then a long vertical blank
    g_req = 1'b1; g_we = 1'b1; g_addr = 8'd50; g_wdata = 3'd3;
    repeat (int'(HBLANK_CYCLES)) run_cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    repeat (5) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    if (g_req) wait_ack(1'b0, 200);
    repeat (3) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Randomized traffic with blank runs of mixed length and rare resets
    g_auto  = 1'b1;
    von_r   = 1'b1;
    vs_r    = 1'b1;
    run_len = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_len == 0) begin
        von_r   = ~von_r;
        run_len = von_r ? int'($urandom_range(1, 60))
                        : (($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 220))
                                                       : int'($urandom_range(1, 40)));
      end
      run_len--;
      if ($urandom_range(0, 49) == 0) vs_r = ~vs_r;
      run_cycle(1'($urandom_range(0, 499) == 0), von_r, vs_r,
                1'($urandom_range(0, 99) < 35),
                ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(180, 255))
                                            : ADDR_W'($urandom_range(0, 199)));
    end
    g_auto = 1'b0;
    repeat (8) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/board_mem_arbiter.md
Name: board_mem_arbiter

Overview:
- Shares one single-port synchronous playfield RAM (one colour code per board cell) between two requesters:
  - the pixel renderer, which reads cells at fixed latency;
  - the game logic, which reads and writes through a req/ack handshake.
- Renderer always has priority. Game logic is granted the port only while the display is blanked.
- Also emits a once-per-frame tick that paces game updates.
- Sits between the VGA sync timing block, the renderer, the game FSM and the board RAM.

Parameters:
- ADDR_W, 8: cell address width.
- DATA_W, 3: cell colour code width.
- CELL_COUNT, 200: number of valid cells (10x20 board); addresses at or above this are out of range.
- HBLANK_CYCLES, 160: length of one horizontal blanking interval in clocks; used for vertical-blank detection.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- video_on  in  1  active-display flag from sync timing
- vsync  in  1  active-low vertical sync from sync timing
- rd_req  in  1  renderer read request, one cycle per read
- rd_addr  in  ADDR_W  renderer cell address
- rd_valid  out  1  renderer data valid pulse
- rd_data  out  DATA_W  renderer cell data
- gl_req  in  1  game request, held until gl_ack
- gl_we  in  1  game write (1) / read (0)
- gl_addr  in  ADDR_W  game cell address
- gl_wdata  in  DATA_W  game write data
- gl_ack  out  1  one-cycle completion pulse
- gl_rdata  out  DATA_W  game read data, valid with gl_ack
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, one cycle after enable
- frame_tick  out  1  one-cycle pulse per frame
- vblank  out  1  vertical blanking window flag

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst is synchronous, active-high.
  - All outputs and state reset to 0; game FSM resets to G_IDLE; previous-vsync register resets to 0.
- Memory port:
  - All mem_* outputs are registered. A decision made in cycle t is driven at t+1.
  - The RAM returns data at t+2.
  - mem_en=0 in any cycle with no grant.
- Renderer path:
  - rd_req in cycle t, in range: RAM read issued at t+1; rd_valid=1 and rd_data=mem_rdata at t+3.
  - Latency is fixed at 3 in every case.
  - Out of range: no RAM access; rd_valid still pulses at t+3 with rd_data=0.
  - Back-to-back rd_req is fully pipelined.
- Game FSM, eligibility: G_IDLE→G_ISSUE in cycle t only when all of the following hold:
  - gl_req=1
  - the window is open (video_on=0, or vblank=1 when WRITE_FENCE_EN is defined)
  - rd_req=0 in cycle t
- Game FSM, transitions:
  - G_ISSUE (t+1): mem access driven.
  - Write: →G_ACK; gl_ack=1 at t+2.
  - Read: →G_RWAIT (t+2) →G_ACK; gl_ack=1 at t+3 with gl_rdata.
  - G_ACK→G_IDLE. A new request is eligible from the cycle after the ack.
- Game FSM, other rules:
  - gl_req is ignored outside G_IDLE.
  - gl_addr/gl_we/gl_wdata are captured at the grant.
  - Out-of-range game write: mem_en stays 0, ack still given on normal timing.
  - Out-of-range game read: ack on normal timing with gl_rdata=0.
- Simultaneous events:
  - rd_req and eligible gl_req in the same cycle: renderer granted, game waits.
  - A renderer read in the cycle after a game issue is legal, because the RAM is pipelined.
  - gl_rdata and rd_data are held in separate registers.
- vblank:
  - A saturating counter counts consecutive video_on=0 cycles.
  - vblank=1 once the count exceeds HBLANK_CYCLES.
  - Counter and vblank clear to 0 in the cycle after video_on rises.
- frame_tick: pulses for 1 cycle when vsync goes 1→0, detected against the registered previous vsync.
- Reset mid-transaction: FSM returns to G_IDLE; no gl_ack is produced; mem_en=0 from the next cycle; pending rd_valid pulses are cancelled.

Optional Feature:
- Macro: WRITE_FENCE_EN.
- Defined:
  - Game writes are granted only when vblank=1, which prevents mid-frame tearing.
  - Game reads keep the normal window (video_on=0).
- Undefined: all game accesses are granted whenever video_on=0, including horizontal blanking.

Test Plan:
- Renderer latency: video_on=1, rd_req at addr 5 (RAM holds 3'd6) → mem_en/mem_addr=5 one cycle later; rd_valid=1 with rd_data=6 exactly 3 cycles after the request.
- Game write then read: video_on=0, write addr 17 data 3'd4 → gl_ack 2 cycles after grant; a following read of addr 17 → gl_ack 3 cycles after its grant with gl_rdata=4.
- Contention: video_on=0, gl_req held and rd_req asserted for 4 consecutive cycles → no game grant during those cycles; game grant in the first cycle with rd_req=0; renderer latency unchanged.
- Blocked window: gl_req held while video_on=1 for 100 cycles → no mem_en from the game and no gl_ack; grant on the first video_on=0 cycle.
- Range and frame tick:
  - gl write to addr 200 → ack, no mem_en.
  - rd addr 250 → rd_valid with data 0.
  - vsync 1→0 → frame_tick high for exactly 1 cycle.
- Reset and fence:
  - rst asserted in G_RWAIT → no gl_ack; all outputs 0 next cycle.
  - With WRITE_FENCE_EN defined: write held through a 160-cycle horizontal blank → no grant; granted once video_on has stayed 0 for 161 cycles.
